fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL declare ports in this order: clk, reset, then the remaining ports below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 npc_in  input  32  next PC produced by the next-PC selector.
REQ-005 stall  input  1  hazard stall; holds the PC and the IF/ID register.
REQ-006 flush  input  1  exception/eret redirect; bubbles IF/ID and loads the PC.
REQ-007 bd_in  input  1  decode-stage branch/jump flag, so the fetched instruction is a delay slot.
REQ-008 instr_in  input  32  instruction word returned combinationally by IM for pc_f.
REQ-009 pc_f  output  32  current fetch PC, to IM and the next-PC selector.
REQ-010 pc_d, instr_d  output  32 each  IF/ID latched PC and instruction.
REQ-011 excode_d  output  5  fetch exception code (0 = none, 4 = AdEL).
REQ-012 bd_d, valid_d  output  1 each  delay-slot flag; 0 marks a bubble.

Function
REQ-013 Per-edge priority SHALL be reset > flush > stall > normal.
REQ-014 Normal edge:
- pc_f <= npc_in.
- IF/ID <= {pc_f, instr_f, excode_f, bd_in, 1}.
REQ-015 Stall edge (flush=0): pc_f and all IF/ID fields SHALL hold.
REQ-016 Flush edge, regardless of stall:
- pc_f <= npc_in.
- IF/ID <= {pc_d=npc_in, instr 0, excode 0, bd 0, valid 0}.
REQ-017 excode_f SHALL be 4 when pc_f[1:0]!=0 or pc_f is outside [0x0000_3000, 0x0000_6FFF]; otherwise it SHALL be 0.
REQ-018 When excode_f!=0, instr_f SHALL be 32'h0; otherwise instr_f SHALL be instr_in.
REQ-019 The fetch path SHALL have one-cycle latency: the instruction fetched at pc_f appears on instr_d after the next non-stalled edge.
REQ-020 No arithmetic SHALL be performed on the PC; npc_in is taken verbatim, and 32-bit wrap is the selector's concern.
REQ-021 A misaligned npc_in SHALL still be loaded into pc_f, and the error SHALL be reported only via excode_d.

Reset
REQ-022 On reset:
- pc_f = 32'h0000_3000.
- pc_d = 32'h0000_3000.
- instr_d = 0, excode_d = 0, bd_d = 0, valid_d = 0.
REQ-023 Reset asserted mid-stall or mid-flush SHALL override both on that edge.
REQ-024 The first edge after reset deassertion SHALL latch the instruction at 0x3000 into IF/ID.

Configuration
REQ-025 Macro FETCH_STAGE_PERF_EN SHALL control performance counters.
- Defined: adds outputs fetch_cnt[31:0] and stall_cnt[31:0].
- fetch_cnt increments on each edge that latches valid_d=1.
- stall_cnt increments on each stall edge with flush=0.
- Both counters reset to 0 and wrap modulo 2^32.
REQ-026 Without FETCH_STAGE_PERF_EN, those ports and registers SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-027 The shared package SHALL hold: PC_RESET=32'h0000_3000, EXC_ENTRY=32'h0000_4180, IM_LO=32'h0000_3000, IM_HI=32'h0000_6FFF, EXC_ADEL=5'd4, EXC_NONE=5'd0.
REQ-028 One sub-module, pc_reg, SHALL hold the PC register with enable/load.
REQ-029 The IF/ID register and exception check SHALL live in fetch_stage.

Verification
REQ-030 Reset, then 3 edges with npc_in = pc_f+4, instr_in = 0x1000_0000: pc_f = 0x3000 -> 0x3004 -> 0x3008 -> 0x300C, pc_d lags by one, valid_d=1.
REQ-031 stall=1 for 2 edges at pc_f=0x3008: pc_f, pc_d and instr_d are unchanged, then resume at 0x300C.
REQ-032 flush=1 and stall=1 together with npc_in=0x4180: pc_f=0x4180, valid_d=0, instr_d=0, pc_d=0x4180.
REQ-033 npc_in=0x3002, then one edge: excode_d=4, instr_d=0, pc_d=0x3002.
REQ-034 npc_in=0x7000, then one edge: excode_d=4; with bd_in=1 on the same edge, bd_d=1.
REQ-035 With FETCH_STAGE_PERF_EN: 5 normal edges plus 2 stall edges plus 1 flush edge give fetch_cnt=5 and stall_cnt=2; asserting reset returns both to 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: reset PC, exception entry, IM window and exception codes.
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6FFF;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;
    localparam logic [4:0]  EXC_NONE  = 5'd0;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: synchronous reset to PC_RESET, loads d when en is high.
module pc_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= PC_RESET;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC register, address check and IF/ID pipeline register.
// Optional performance counters (fetch_cnt, stall_cnt) when FETCH_STAGE_PERF_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        bd_in,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] instr_d,
    output logic [4:0]  excode_d,
    output logic        bd_d,
    output logic        valid_d
`ifdef FETCH_STAGE_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    logic [4:0]  excode_f;
    logic [31:0] instr_f;
    logic        pc_en;

    // A flush redirects the PC even while the hazard unit is stalling.
    assign pc_en = flush | ~stall;

    pc_reg u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (npc_in),
        .q     (pc_f)
    );

    always_comb begin
        excode_f = EXC_NONE;
        if ((pc_f[1:0] != 2'b00) || (pc_f < IM_LO) || (pc_f > IM_HI))
            excode_f = EXC_ADEL;
        instr_f = (excode_f != EXC_NONE) ? '0 : instr_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_d     <= PC_RESET;
            instr_d  <= '0;
            excode_d <= EXC_NONE;
            bd_d     <= 1'b0;
            valid_d  <= 1'b0;
        end else if (flush) begin
            pc_d     <= npc_in;
            instr_d  <= '0;
            excode_d <= EXC_NONE;
            bd_d     <= 1'b0;
            valid_d  <= 1'b0;
        end else if (!stall) begin
            pc_d     <= pc_f;
            instr_d  <= instr_f;
            excode_d <= excode_f;
            bd_d     <= bd_in;
            valid_d  <= 1'b1;
        end
    end

`ifdef FETCH_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else if (!flush) begin
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
            else
                fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule
